f_register_file: RTL and testbench

- 16 x 16-bit general ("f") register file with two read ports and one write port.
- Sits directly upstream of the f-register backup stack. On a call it drives the flattened 256-bit snapshot and a one-cycle `backup` pulse into the stack. On a return it pulses `restore`, waits for the stack's restore-valid strobe, then bulk-loads all registers from the stack's 256-bit data.
- Tracks stack depth and flags overflow, underflow, protocol and timeout errors.

---
 rtl/f_register_file.sv | 162 ++++++++++++++++
 tb/tb_f_register_file.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/f_register_file.sv
// f_register_file: 16 x 16-bit general register file with two combinational
// read ports and one write port. It also runs the call/return handshake with
// the downstream f-register backup stack. A call pushes a 256-bit snapshot.
// A return pops a frame and bulk-loads it into the registers.
module f_register_file #(
  parameter int REG_W           = 16,
  parameter int NREGS           = 16,
  parameter int STACK_DEPTH     = 16,
  parameter int DEPTH_W         = 5,
  parameter int RESTORE_TIMEOUT = 8,
  localparam int AW             = $clog2(NREGS),
  localparam int SNAP_W         = REG_W * NREGS,
  localparam int TMO_W          = $clog2(RESTORE_TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [REG_W-1:0]   wr_data,
  input  logic [AW-1:0]      rd_addr_a,
  output logic [REG_W-1:0]   rd_data_a,
  input  logic [AW-1:0]      rd_addr_b,
  output logic [REG_W-1:0]   rd_data_b,
  input  logic               call_req,
  input  logic               ret_req,
  output logic               busy,
  output logic               backup,
  output logic               restore,
  output logic [SNAP_W-1:0]  snapshot,
  input  logic [SNAP_W-1:0]  restore_data,
  input  logic               restore_valid,
  output logic [DEPTH_W-1:0] depth,
  output logic               overflow,
  output logic               underflow,
  output logic               proto_err,
  output logic               timeout_err
);

  typedef enum logic [1:0] {IDLE, BACKUP, RESTORE, LOAD} state_t;

  state_t             state, state_next;
  logic [REG_W-1:0]   regs [NREGS];
  logic [SNAP_W-1:0]  hold;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               call_go;
  logic               set_ovf, set_unf, set_proto, set_tmo;
  logic               write_ok;
  // A write in the same cycle as an accepted call is held here.
  // It lands at the end of BACKUP, so it stays out of the pushed frame.
  logic               pend_vld;
  logic [AW-1:0]      pend_addr;
  logic [REG_W-1:0]   pend_data;

  // Next-state decode and request arbitration; requests only count in IDLE
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_next = state;
    call_go    = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    set_proto  = 1'b0;
    set_tmo    = 1'b0;
    case (state)
      IDLE: begin
        if (call_req && ret_req) begin
          set_proto = 1'b1;
        end else if (call_req) begin
          if (depth == DEPTH_W'(STACK_DEPTH)) begin
            set_ovf = 1'b1;
          end else begin
            call_go    = 1'b1;
            state_next = BACKUP;
          end
        end else if (ret_req) begin
          if (depth == '0) set_unf = 1'b1;
          else             state_next = RESTORE;
        end
      end
      BACKUP:  state_next = IDLE;
      RESTORE: begin
        if (restore_valid) begin
          state_next = LOAD;
        end else if (tmo_cnt == TMO_W'(RESTORE_TIMEOUT - 1)) begin
          set_tmo    = 1'b1;
          state_next = IDLE;
        end
      end
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign backup   = (state == BACKUP);
  assign restore  = (state == RESTORE) && (tmo_cnt == '0);
  assign write_ok = wr_en && (wr_addr != '0) &&
                    (state == BACKUP || (state == IDLE && !call_go));

  // Control state: FSM, depth counter, restore timeout counter, sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      depth       <= '0;
      tmo_cnt     <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      proto_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state <= state_next;
      if (state == BACKUP) depth <= depth + DEPTH_W'(1);
      if (state == LOAD)   depth <= depth - DEPTH_W'(1);
      if (state == RESTORE) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                  tmo_cnt <= '0;
      if (set_ovf)   overflow    <= 1'b1;
      if (set_unf)   underflow   <= 1'b1;
      if (set_proto) proto_err   <= 1'b1;
      if (set_tmo)   timeout_err <= 1'b1;
    end
  end

  // Register array: bulk load in LOAD, otherwise deferred and direct writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      pend_vld  <= call_go && wr_en && (wr_addr != '0);
      pend_addr <= wr_addr;
      pend_data <= wr_data;
      if (state == LOAD) begin
        for (int i = 0; i < NREGS; i++)
          regs[i] <= (i == 0) ? '0 : hold[i*REG_W +: REG_W];
      end else begin
        // The deferred call-cycle write goes first; a BACKUP-cycle write to
        // the same register is newer and wins.
        if (pend_vld) regs[pend_addr] <= pend_data;
        if (write_ok) regs[wr_addr]   <= wr_data;
      end
    end
  end

  // Frame holding register: captures the stack's data on restore_valid
  always_ff @(posedge clk) begin
    // NOTE: this wide datapath register is deliberately not reset. It is only
    // read in LOAD, and LOAD is reachable only right after a capture.
    if (state == RESTORE && restore_valid) hold <= restore_data;
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

  for (genvar g = 0; g < NREGS; g++) begin : g_snap
    assign snapshot[g*REG_W +: REG_W] = regs[g];
  end

endmodule

// File: tb/tb_f_register_file.sv
// Self-checking bench for f_register_file. A behavioural model keeps the
// architectural registers, a queue of pushed frames, the depth and the sticky
// flags. The bench plays the backup stack, returning frames from the model.
module tb_f_register_file;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en, call_req, ret_req, restore_valid;
  logic [3:0]   wr_addr, rd_addr_a, rd_addr_b;
  logic [15:0]  wr_data, rd_data_a, rd_data_b;
  logic         busy, backup, restore;
  logic [255:0] snapshot, restore_data;
  logic [4:0]   depth;
  logic         overflow, underflow, proto_err, timeout_err;

  f_register_file dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .call_req(call_req), .ret_req(ret_req),
    .busy(busy), .backup(backup), .restore(restore),
    .snapshot(snapshot), .restore_data(restore_data), .restore_valid(restore_valid),
    .depth(depth), .overflow(overflow), .underflow(underflow),
    .proto_err(proto_err), .timeout_err(timeout_err)
  );

  always #50 clk = ~clk;

  // Reference model
  logic [15:0]  m_regs [16];
  logic [255:0] m_frames [$];
  int           m_depth;
  bit           m_ovf, m_unf, m_proto, m_tmo;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pack_model();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_frames.delete();
    m_depth = 0;
    {m_ovf, m_unf, m_proto, m_tmo} = '0;
  endtask

  // Idle-state comparison of everything visible
  task automatic check_state(input string tag);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_depth"}, depth, m_depth);
    check({tag, "_flags"}, {overflow, underflow, proto_err, timeout_err},
          {m_ovf, m_unf, m_proto, m_tmo});
    check({tag, "_snap"},  snapshot, pack_model());
  endtask

  task automatic check_reads();
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      #1;
      check("rd_a", rd_data_a, m_regs[i]);
      check("rd_b", rd_data_b, m_regs[15 - i]);
    end
  endtask

  // All tasks start and end right after a falling edge.
  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    restore_valid = 1'($urandom);
    restore_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    wr_en = 1'b0; restore_valid = 1'b0;
    if (a != 0) m_regs[a] = d;
    check("wr_snap", snapshot, pack_model());
  endtask

  task automatic do_call(input bit wr, input logic [3:0] a, input logic [15:0] d, input bit poke);
    bit ok;
    ok = (m_depth < 16);
    call_req = 1'b1; wr_en = wr; wr_addr = a; wr_data = d;
    @(negedge clk);
    call_req = poke && ok; wr_en = 1'b0;
    if (ok) begin
      check("bkp_pulse", backup, 1'b1);
      check("bkp_busy", busy, 1'b1);
      check("bkp_frame", snapshot, pack_model());
      m_frames.push_back(pack_model());
      m_depth++;
    end else begin
      check("ovf_no_pulse", backup, 1'b0);
      m_ovf = 1'b1;
    end
    if (wr && a != 0) m_regs[a] = d;
    if (ok) begin
      @(negedge clk);
      call_req = 1'b0;
      check("bkp_one_cycle", backup, 1'b0);
    end
    check_state("call");
  endtask

  // dly 0..7: restore_valid after dly wait cycles; dly >= 8: never
  task automatic do_ret(input int dly, input bit poke);
    logic [255:0] frame;
    bit accepted;
    accepted = 1'b0;
    ret_req = 1'b1;
    @(negedge clk);
    ret_req = 1'b0;
    if (m_depth == 0) begin
      m_unf = 1'b1;
      check("unf_no_strobe", {restore, backup}, 2'b00);
      check_state("unf");
      return;
    end
    check("ret_pulse", {busy, restore}, 2'b11);
    frame = m_frames[$];
    for (int c = 0; c < 8; c++) begin
      if (c > 0) check("ret_wait", {busy, restore}, 2'b10);
      wr_en = 1'b1; wr_addr = 4'($urandom_range(1, 15)); wr_data = 16'($urandom);
      if (c == dly) begin
        restore_valid = 1'b1;
        restore_data  = {frame[255:16], 16'($urandom)};
        @(negedge clk);
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    restore_valid = 1'b0; wr_en = 1'b0;
    if (accepted) begin
      check("load_busy", {busy, restore}, 2'b10);
      ret_req = poke;
      @(negedge clk);
      ret_req = 1'b0;
      void'(m_frames.pop_back());
      for (int i = 0; i < 16; i++) m_regs[i] = (i == 0) ? 16'h0 : frame[i*16 +: 16];
      m_depth--;
    end else begin
      m_tmo = 1'b1;
    end
    check_state("ret");
  endtask

  task automatic do_both();
    call_req = 1'b1; ret_req = 1'b1;
    @(negedge clk);
    call_req = 1'b0; ret_req = 1'b0;
    m_proto = 1'b1;
    check("proto_no_strobe", {backup, restore}, 2'b00);
    check_state("proto");
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_out", {busy, backup, restore, overflow, underflow, proto_err, timeout_err}, 7'b0);
    check("rst_depth", depth, 5'd0);
    check("rst_snap", snapshot, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    {wr_en, call_req, ret_req, restore_valid} = '0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0; restore_data = '0;
    model_reset();
    @(negedge clk);
    do_reset();
    check_state("reset");

    // Fill r1..r15, then attempt to write r0
    for (int i = 1; i < 16; i++) do_write(4'(i), 16'(16'h0011 * i));
    check_reads();
    do_write(4'd0, 16'hFFFF);
    check_reads();
    check("snap_r0", snapshot[15:0], 16'h0);

    // Single call/return round trip with same-cycle write on the call
    do_write(4'd5, 16'h1234);
    do_call(1'b1, 4'd5, 16'h5555, 1'b1);
    check("r5_after_call", snapshot[95:80], 16'h5555);
    do_write(4'd5, 16'hBEEF);
    do_ret(1, 1'b1);
    check("r5_restored", snapshot[95:80], 16'h1234);
    check_reads();

    // Fill the stack, overflow, drain it, underflow
    for (int i = 0; i < 17; i++) begin
      do_write(4'($urandom_range(0, 15)), 16'($urandom));
      do_call(1'($urandom), 4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom));
    end
    check("ovf_depth", depth, 5'd16);
    for (int i = 0; i < 17; i++) do_ret((i == 0) ? 7 : $urandom_range(0, 7), 1'($urandom));
    check_reads();

    // Simultaneous call and return at depth 3
    do_reset();
    for (int i = 0; i < 3; i++) do_call(1'b0, 4'd0, 16'h0, 1'b0);
    do_both();

    // Return that never gets restore_valid
    do_write(4'd7, 16'hA5A5);
    do_ret(8, 1'b0);
    check_reads();

    // Reset in the middle of RESTORE, then a stray restore_valid
    ret_req = 1'b1;
    @(negedge clk);
    ret_req = 1'b0;
    check("pre_rst_restore", restore, 1'b1);
    do_reset();
    restore_valid = 1'b1;
    restore_data  = {16{16'hC3C3}};
    @(negedge clk);
    @(negedge clk);
    restore_valid = 1'b0;
    check_state("stray_valid");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int op;
      op = $urandom_range(0, 19);
      if (op < 8)       do_write(4'($urandom_range(0, 15)), 16'($urandom));
      else if (op < 13) do_call(1'($urandom), 4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom));
      else if (op < 18) do_ret($urandom_range(0, 7), 1'($urandom));
      else if (op < 19) do_ret(8, 1'b0);
      else              do_both();
      rd_addr_a = 4'($urandom); rd_addr_b = 4'($urandom);
      #1;
      check("rnd_rd_a", rd_data_a, m_regs[rd_addr_a]);
      check("rnd_rd_b", rd_data_b, m_regs[rd_addr_b]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
